// File: rtl/memory.sv
// Memory stage: issues data-bus requests for loads/stores, aligns store data,
// extracts load data and stalls the pipeline while a transaction is in flight.

package memory_pkg;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] msize;
    logic       mem_unsigned;
  } control_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] sextimm;
    logic [63:0] srcb;
    logic [4:0]  dst;
    logic        valid;
    logic [63:0] alu_out;
    control_t    ctl;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  dst;
    logic        valid;
    control_t    ctl;
    logic [63:0] alu_out;
    logic [63:0] rdata;
    logic        misalign;
  } memory_data_t;

endpackage

module memory
  import memory_pkg::*;
#(
  parameter int unsigned AW = 64,
  parameter int unsigned DW = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  execute_data_t       dataE,
  input  logic                stall_in,
  output logic                dreq_valid,
  output logic [AW-1:0]       dreq_addr,
  output logic [1:0]          dreq_size,
  output logic [DW/8-1:0]     dreq_strobe,
  output logic [DW-1:0]       dreq_data,
  input  logic                dresp_addr_ok,
  input  logic                dresp_data_ok,
  input  logic [DW-1:0]       dresp_data,
  output memory_data_t        dataM,
  output logic [63:0]         aluoutM,
  output logic                m_wait
);

  localparam int unsigned StrbW = DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t             state;
  state_t             nextState;
  logic [63:0]        captured;
  logic               complete;
  logic               reqValid;

  logic [2:0]         off;
  logic [5:0]         laneShift;
  logic [2:0]         alignMask;
  logic               isMemOp;
  logic               misaligned;
  logic               active;
  logic [63:0]        lane;
  logic [63:0]        loadValue;
  logic [StrbW-1:0]   strobeMask;

  // Immediate is not used in this stage.
  logic unusedBits;
  assign unusedBits = ^dataE.sextimm;

  assign off       = dataE.alu_out[2:0];
  assign laneShift = {off, 3'b000};
  assign isMemOp   = dataE.valid && (dataE.ctl.memread || dataE.ctl.memwrite);
  assign misaligned = isMemOp && (|(off & alignMask));
  assign active    = isMemOp && !misaligned;
  assign aluoutM   = dataE.alu_out;

  // Low address bits that must be zero for the access size.
  always_comb begin
    alignMask = 3'b000;
    case (dataE.ctl.msize)
      2'd0: alignMask = 3'b000;
      2'd1: alignMask = 3'b001;
      2'd2: alignMask = 3'b011;
      2'd3: alignMask = 3'b111;
    endcase
  end

  // Byte-lane write enables for the access size at the current offset.
  always_comb begin
    strobeMask = '0;
    case (dataE.ctl.msize)
      2'd0: strobeMask = StrbW'(8'h01) << off;
      2'd1: strobeMask = StrbW'(8'h03) << off;
      2'd2: strobeMask = StrbW'(8'h0F) << off;
      2'd3: strobeMask = StrbW'(8'hFF);
    endcase
  end

  // Shift the addressed lane down and zero/sign-extend it to 64 bits.
  always_comb begin
    lane      = 64'(dresp_data >> laneShift);
    loadValue = lane;
    case (dataE.ctl.msize)
      2'd0: loadValue = dataE.ctl.mem_unsigned ? {56'd0, lane[7:0]}
                                               : {{56{lane[7]}}, lane[7:0]};
      2'd1: loadValue = dataE.ctl.mem_unsigned ? {48'd0, lane[15:0]}
                                               : {{48{lane[15]}}, lane[15:0]};
      2'd2: loadValue = dataE.ctl.mem_unsigned ? {32'd0, lane[31:0]}
                                               : {{32{lane[31]}}, lane[31:0]};
      2'd3: loadValue = lane;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Load result kept for replay while the pipeline is held downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      captured <= 64'd0;
    end else if (complete) begin
      captured <= loadValue;
    end
  end

  // Next-state and bus/pipeline outputs.
  always_comb begin
    nextState   = state;
    complete    = 1'b0;
    reqValid    = 1'b0;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = 2'd0;
    dreq_strobe = '0;
    dreq_data   = '0;
    m_wait      = 1'b0;
    dataM       = '0;

    case (state)
      IDLE, ADDR: begin
        if (active) begin
          reqValid = 1'b1;
          if (dresp_addr_ok && dresp_data_ok) begin
            complete  = 1'b1;
            nextState = stall_in ? HOLD : IDLE;
          end else if (dresp_addr_ok) begin
            nextState = DATA;
          end else begin
            nextState = ADDR;
          end
        end else begin
          nextState = IDLE;
        end
      end
      DATA: begin
        if (dresp_data_ok) begin
          complete  = 1'b1;
          nextState = stall_in ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!stall_in) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase

    dataM.pc      = dataE.pc;
    dataM.dst     = dataE.dst;
    dataM.valid   = dataE.valid;
    dataM.ctl     = dataE.ctl;
    dataM.alu_out = dataE.alu_out;

    if (!reset) begin
      dreq_valid     = reqValid;
      dreq_addr      = AW'(dataE.alu_out);
      dreq_size      = dataE.ctl.msize;
      dreq_strobe    = (active && dataE.ctl.memwrite) ? strobeMask : '0;
      dreq_data      = DW'(dataE.srcb) << laneShift;
      m_wait         = active && !complete && (state != HOLD);
      dataM.misalign = misaligned;
      if (complete) begin
        dataM.rdata = loadValue;
      end else if (state == HOLD) begin
        dataM.rdata = captured;
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage: vector table, directed multi-cycle
// sequences and randomized operations against a byte-level reference model.

module tb_memory;
  import memory_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  execute_data_t dataE;
  logic          stall_in;
  logic          dreq_valid;
  logic [63:0]   dreq_addr;
  logic [1:0]    dreq_size;
  logic [7:0]    dreq_strobe;
  logic [63:0]   dreq_data;
  logic          dresp_addr_ok;
  logic          dresp_data_ok;
  logic [63:0]   dresp_data;
  memory_data_t  dataM;
  logic [63:0]   aluoutM;
  logic          m_wait;

  int testsRun = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memory #(.AW(64), .DW(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .dataE         (dataE),
    .stall_in      (stall_in),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_size     (dreq_size),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .dataM         (dataM),
    .aluoutM       (aluoutM),
    .m_wait        (m_wait)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Reference model: byte-lane view of an aligned access.
  function automatic bit refMisaligned(input logic [63:0] addr, input logic [1:0] size);
    int o = int'(addr[2:0]);
    int n = 1 << size;
    return (o % n) != 0;
  endfunction

  function automatic logic [7:0] refStrobe(input logic [63:0] addr, input logic [1:0] size);
    int o = int'(addr[2:0]);
    int n = 1 << size;
    logic [7:0] s = 8'h00;
    for (int b = 0; b < 8; b++) if (b >= o && b < o + n) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] refStoreData(input logic [63:0] srcb, input logic [63:0] addr);
    int o = int'(addr[2:0]);
    logic [63:0] d = 64'd0;
    for (int i = 0; i < 8 - o; i++) d[8*(o+i) +: 8] = srcb[8*i +: 8];
    return d;
  endfunction

  function automatic logic [63:0] refLoad(input logic [63:0] resp, input logic [63:0] addr,
                                          input logic [1:0] size, input logic uns);
    int o = int'(addr[2:0]);
    int n = 1 << size;
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = resp[8*(o+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic setOp(input logic valid, input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [63:0] addr, input logic [63:0] srcb);
    dataE                  = '0;
    dataE.pc               = {32'd0, $urandom};
    dataE.sextimm          = {$urandom, $urandom};
    dataE.srcb             = srcb;
    dataE.dst              = 5'd7;
    dataE.valid            = valid;
    dataE.alu_out          = addr;
    dataE.ctl.regwrite     = rd;
    dataE.ctl.memread      = rd;
    dataE.ctl.memwrite     = wr;
    dataE.ctl.msize        = size;
    dataE.ctl.mem_unsigned = uns;
  endtask

  task automatic setNop();
    dataE         = '0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    stall_in      = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One aligned op: addr_ok in cycle latA, data_ok latD cycles later, then
  // holdK cycles in which the result must be replayed (stall high except the last).
  task automatic runOp(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] srcb, input logic [63:0] respIn,
                       input int latA, input int latD, input int holdK);
    int          done = latA + latD;
    logic [63:0] resp = wr ? 64'd0 : respIn;
    logic [63:0] expR = refLoad(resp, addr, size, uns);
    logic [7:0]  expS = wr ? refStrobe(addr, size) : 8'h00;
    setOp(1'b1, !wr, wr, size, uns, addr, srcb);
    for (int c = 0; c <= done; c++) begin
      dresp_addr_ok = (c == latA);
      dresp_data_ok = (c == done);
      stall_in      = (c == done) && (holdK > 0);
      dresp_data    = (c == done) ? resp : {$urandom, $urandom};
      @(negedge clk);
      chk($sformatf("%s.c%0d.dreq_valid", tag, c), 64'(dreq_valid), 64'(c <= latA));
      chk($sformatf("%s.c%0d.m_wait", tag, c), 64'(m_wait), 64'(c < done));
      chk($sformatf("%s.c%0d.rdata", tag, c), dataM.rdata, (c == done) ? expR : 64'd0);
      if (c == 0) begin
        chk($sformatf("%s.addr", tag), dreq_addr, addr);
        chk($sformatf("%s.size", tag), 64'(dreq_size), 64'(size));
        chk($sformatf("%s.strobe", tag), 64'(dreq_strobe), 64'(expS));
        if (wr) chk($sformatf("%s.wdata", tag), dreq_data, refStoreData(srcb, addr));
      end
      nextCycle();
    end
    for (int h = 0; h < holdK; h++) begin
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b1;
      dresp_data    = {$urandom, $urandom};
      stall_in      = (h < holdK - 1);
      @(negedge clk);
      chk($sformatf("%s.h%0d.dreq_valid", tag, h), 64'(dreq_valid), 64'd0);
      chk($sformatf("%s.h%0d.m_wait", tag, h), 64'(m_wait), 64'd0);
      chk($sformatf("%s.h%0d.rdata", tag, h), dataM.rdata, expR);
      nextCycle();
    end
    setNop();
  endtask

  typedef struct {
    logic        valid, rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr, srcb, resp;
    logic        addrOk, dataOk;
    logic        expValid, expWait;
    logic [7:0]  expStrobe;
    logic [63:0] expData;
    logic        expMis;
    logic [63:0] expRdata;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1,1,0,2'd3,0,64'h80000008,64'h0,64'h1122334455667788,1,1, 1,0,8'h00,64'h0,0,64'h1122334455667788};
    vecs[1]  = '{1,1,0,2'd0,0,64'h80000003,64'h0,64'h0000000080000000,1,1, 1,0,8'h00,64'h0,0,64'hFFFFFFFFFFFFFF80};
    vecs[2]  = '{1,1,0,2'd0,1,64'h80000003,64'h0,64'h0000000080000000,1,1, 1,0,8'h00,64'h0,0,64'h0000000000000080};
    vecs[3]  = '{1,0,1,2'd1,0,64'h80000006,64'hBEEF,64'h0,1,1, 1,0,8'hC0,64'hBEEF000000000000,0,64'h0};
    vecs[4]  = '{1,1,0,2'd2,0,64'h80000002,64'h0,64'hDEADBEEFDEADBEEF,0,0, 0,0,8'h00,64'h0,1,64'h0};
    vecs[5]  = '{1,0,0,2'd3,0,64'h80000010,64'h0,64'hDEADBEEFDEADBEEF,0,1, 0,0,8'h00,64'h0,0,64'h0};
    vecs[6]  = '{0,1,0,2'd2,0,64'h80000004,64'h0,64'hDEADBEEFDEADBEEF,1,1, 0,0,8'h00,64'h0,0,64'h0};
    vecs[7]  = '{1,1,0,2'd1,1,64'h80000006,64'h0,64'hF00D000000000000,1,1, 1,0,8'h00,64'h0,0,64'h000000000000F00D};
    vecs[8]  = '{1,1,0,2'd1,0,64'h80000006,64'h0,64'hF00D000000000000,1,1, 1,0,8'h00,64'h0,0,64'hFFFFFFFFFFFFF00D};
    vecs[9]  = '{1,0,1,2'd2,0,64'h80000004,64'h12345678,64'h0,1,1, 1,0,8'hF0,64'h1234567800000000,0,64'h0};
    vecs[10] = '{1,0,1,2'd0,0,64'h80000007,64'hAB,64'h0,1,1, 1,0,8'h80,64'hAB00000000000000,0,64'h0};
    vecs[11] = '{1,0,1,2'd3,0,64'h80000000,64'h0123456789ABCDEF,64'h0,1,1, 1,0,8'hFF,64'h0123456789ABCDEF,0,64'h0};
    vecs[12] = '{1,1,0,2'd2,1,64'h80000004,64'h0,64'h89ABCDEF00000000,1,1, 1,0,8'h00,64'h0,0,64'h0000000089ABCDEF};
    vecs[13] = '{1,1,0,2'd2,0,64'h80000004,64'h0,64'h89ABCDEF00000000,1,1, 1,0,8'h00,64'h0,0,64'hFFFFFFFF89ABCDEF};
    vecs[14] = '{1,0,1,2'd3,0,64'h80000004,64'h0,64'h0,1,1, 0,0,8'h00,64'h0,1,64'h0};

    // Reset with a live load presented: only the passthroughs may be non-zero.
    reset = 1'b1;
    setNop();
    setOp(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h80000020, 64'h0);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'hCAFEF00DCAFEF00D;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst.m_wait", 64'(m_wait), 64'd0);
    chk("rst.rdata", dataM.rdata, 64'd0);
    chk("rst.misalign", 64'(dataM.misalign), 64'd0);
    chk("rst.dreq_addr", dreq_addr, 64'd0);
    chk("rst.aluoutM", aluoutM, 64'h80000020);
    chk("rst.pc", dataM.pc, dataE.pc);
    nextCycle();
    reset = 1'b0;
    setNop();
    nextCycle();

    // Single-cycle vector table, each leaving the stage idle.
    for (int i = 0; i < 15; i++) begin
      setOp(vecs[i].valid, vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].srcb);
      dresp_addr_ok = vecs[i].addrOk;
      dresp_data_ok = vecs[i].dataOk;
      dresp_data    = vecs[i].resp;
      stall_in      = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d.dreq_valid", i), 64'(dreq_valid), 64'(vecs[i].expValid));
      chk($sformatf("vec%0d.m_wait", i), 64'(m_wait), 64'(vecs[i].expWait));
      chk($sformatf("vec%0d.strobe", i), 64'(dreq_strobe), 64'(vecs[i].expStrobe));
      chk($sformatf("vec%0d.misalign", i), 64'(dataM.misalign), 64'(vecs[i].expMis));
      chk($sformatf("vec%0d.rdata", i), dataM.rdata, vecs[i].expRdata);
      chk($sformatf("vec%0d.dreq_addr", i), dreq_addr, vecs[i].addr);
      chk($sformatf("vec%0d.aluoutM", i), aluoutM, vecs[i].addr);
      if (vecs[i].wr) chk($sformatf("vec%0d.wdata", i), dreq_data, vecs[i].expData);
      nextCycle();
    end
    setNop();
    nextCycle();

    // Directed multi-cycle sequences.
    runOp("ld_fast", 1'b0, 2'd3, 1'b0, 64'h80000008, 64'h0, 64'h1122334455667788, 0, 0, 0);
    runOp("lb_slow", 1'b0, 2'd0, 1'b0, 64'h80000003, 64'h0, 64'h0000000080000000, 2, 3, 0);
    runOp("lbu_slow", 1'b0, 2'd0, 1'b1, 64'h80000003, 64'h0, 64'h0000000080000000, 2, 3, 0);
    runOp("sh_slow", 1'b1, 2'd1, 1'b0, 64'h80000006, 64'hBEEF, 64'h0, 1, 2, 0);
    runOp("lw_hold", 1'b0, 2'd2, 1'b0, 64'h80000004, 64'h0, 64'h8765432100000000, 1, 1, 3);
    runOp("ld_after_hold", 1'b0, 2'd3, 1'b0, 64'h80000018, 64'h0, 64'h0A0B0C0D0E0F1011, 0, 0, 0);

    // Reset while waiting for data; later data_ok must be ignored.
    setOp(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 64'h80000010, 64'h0);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk("rstdata.pre.m_wait", 64'(m_wait), 64'd1);
    nextCycle();
    dresp_addr_ok = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rstdata.rst.dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rstdata.rst.m_wait", 64'(m_wait), 64'd0);
    nextCycle();
    reset = 1'b0;
    setNop();
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h5555AAAA5555AAAA;
    @(negedge clk);
    chk("rstdata.post.dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rstdata.post.m_wait", 64'(m_wait), 64'd0);
    chk("rstdata.post.rdata", dataM.rdata, 64'd0);
    nextCycle();
    setNop();
    runOp("after_rst", 1'b0, 2'd2, 1'b1, 64'h80000008, 64'h0, 64'h00000000FEDCBA98, 0, 0, 0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  size = 2'($urandom_range(0, 3));
      logic        wr   = 1'($urandom_range(0, 1));
      logic        uns  = 1'($urandom_range(0, 1));
      int          o;
      logic [63:0] addr;
      logic [63:0] srcb = {$urandom, $urandom};
      logic [63:0] resp = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) o = $urandom_range(0, 7);
      else o = ($urandom_range(0, 7) >> size) << size;
      addr = 64'h80000000 + 64'($urandom & 32'h0000_0FF8) + 64'(o);
      if (refMisaligned(addr, size)) begin
        setOp(1'b1, !wr, wr, size, uns, addr, srcb);
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = resp;
        @(negedge clk);
        chk($sformatf("rnd%0d.mis.dreq_valid", n), 64'(dreq_valid), 64'd0);
        chk($sformatf("rnd%0d.mis.m_wait", n), 64'(m_wait), 64'd0);
        chk($sformatf("rnd%0d.mis.misalign", n), 64'(dataM.misalign), 64'd1);
        chk($sformatf("rnd%0d.mis.strobe", n), 64'(dreq_strobe), 64'd0);
        chk($sformatf("rnd%0d.mis.rdata", n), dataM.rdata, 64'd0);
        nextCycle();
        setNop();
      end else begin
        runOp($sformatf("rnd%0d", n), wr, size, uns, addr, srcb, resp,
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Memory stage of the 5-stage RISC-V pipeline. It consumes the execute-stage bundle (execute_data_t) and issues load/store requests on the data bus.
- It extracts and sign-extends load data, generates store byte strobes and shifted write data, and produces the memory-stage bundle plus the aluoutM forwarding value.
- It drives m_wait to stall the pipeline while a bus transaction is outstanding, symmetric to e_wait from execute.

Parameters:
AW, 64, data-bus address width.
DW, 64, data-bus data width; strobe width is DW/8.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dataE  in  execute_data_t  pc, sextimm, srcb, dst, valid, alu_out, ctl (uses ctl.memread, ctl.memwrite, ctl.msize[1:0], ctl.mem_unsigned)
stall_in  in  1  downstream/hazard hold; the memory input register is frozen while high
dreq_valid  out  1  bus request valid
dreq_addr  out  AW  request address, equal to dataE.alu_out
dreq_size  out  2  0=byte, 1=half, 2=word, 3=double
dreq_strobe  out  DW/8  byte write enables; 0 for loads
dreq_data  out  DW  write data aligned to byte lane
dresp_addr_ok  in  1  request accepted
dresp_data_ok  in  1  transaction complete; read data valid
dresp_data  in  DW  read data (full 64-bit lane)
dataM  out  memory_data_t  pc, dst, valid, ctl, alu_out, rdata (extracted load value), misalign
aluoutM  out  64  forwarding value, equal to dataE.alu_out
m_wait  out  1  memory stall request

Behaviour:
- Memory op: dataE.valid && (ctl.memread || ctl.memwrite).
- Misaligned: addr[2:0] is not a multiple of 2^msize.
- FSM states:
  - IDLE: no transaction in flight.
  - ADDR: request asserted, waiting for addr_ok.
  - DATA: address accepted, waiting for data_ok.
  - HOLD: result captured, waiting for stall_in to drop.
- IDLE: dreq_valid is asserted combinationally in the same cycle a non-misaligned memory op is present (zero bubble).
  - addr_ok && data_ok in that cycle: op completes, m_wait=0, rdata taken from dresp_data. If stall_in=1, data is registered and the next state is HOLD.
  - addr_ok only: next state DATA.
  - Neither: next state ADDR.
- ADDR: dreq_valid stays high; addr, size, strobe and data are stable (derived from the frozen dataE).
  - addr_ok && data_ok: complete.
  - addr_ok only: next state DATA.
- DATA: dreq_valid=0; on data_ok the op completes. Next state is IDLE, or HOLD if stall_in=1.
- HOLD: m_wait=0; dataM.rdata is driven from the captured register. Return to IDLE on the first cycle with stall_in=0. No new request is issued in HOLD.
- m_wait = memory op present && !misaligned && !(completion this cycle) && state != HOLD.
- Store strobe (off = addr[2:0]):
  - byte: 8'h01<<off
  - half: 8'h03<<off
  - word: 8'h0F<<off
  - double: 8'hFF
- Store data: dataE.srcb << (8*off).
- Load extraction: lane = dresp_data >> (8*off), truncated to msize.
  - Zero-extend if ctl.mem_unsigned, otherwise sign-extend to 64 bits.
  - A double load ignores mem_unsigned.
- Misaligned op: no bus request, m_wait=0, dataM.misalign=1, rdata=0, strobe=0.
- Non-memory or invalid dataE: dreq_valid=0, m_wait=0, rdata=0, misalign=0.
- dataM.pc, dst, valid, ctl and alu_out pass through from dataE combinationally. aluoutM = dataE.alu_out.
- Reset:
  - State returns to IDLE and the capture register is cleared.
  - All outputs are 0 during reset except the dataE passthroughs.
  - A reset mid-transaction abandons the request; the bus is reset on the same cycle.
- data_ok arriving in IDLE or HOLD (spurious) is ignored.

Test Plan:
- Aligned ld at addr 0x80000008, addr_ok and data_ok in the same cycle as the request, data=0x1122334455667788 -> m_wait never high, rdata=0x1122334455667788, one dreq_valid cycle.
- lb at addr 0x80000003, unsigned=0, addr_ok after 2 cycles, data_ok 3 cycles later, byte lane 3=0x80:
  - m_wait high for 5 cycles, low in the data_ok cycle.
  - rdata=0xFFFFFFFFFFFFFF80; with unsigned=1, rdata=0x80.
- sh at addr 0x80000006 with srcb=0xBEEF -> dreq_strobe=8'hC0, dreq_data[63:48]=0xBEEF, size=1; completes on data_ok.
- lw at addr 0x80000002 (misaligned) -> dreq_valid=0, m_wait=0, misalign=1.
- lw completes while stall_in=1 for 3 cycles -> state HOLD, rdata stable for all 3 cycles, no second request, IDLE when stall_in drops.
- reset asserted while in DATA -> next cycle state IDLE, dreq_valid=0, m_wait=0; a later data_ok is ignored.
